rv32i_regfile: RTL and testbench
================================

Name: rv32i_regfile

Overview:
- 32 x 32-bit integer register file for the RV32I core.
- Two asynchronous (combinational) read ports serve the decode stage: rs1 drives RD1, and rs2 drives WriteData, which is the store-data/ALU-B operand.
- One synchronous write port is driven by the writeback Result.
- x0 is hardwired to zero.

Parameters:
- XLEN, 32, data width of each register and of all data ports.
- NREGS, 32, number of architectural registers; address width is log2(NREGS) = 5.
- BYPASS, 0, when 1 a read of the register being written in the same cycle returns Result (write-through); when 0 it returns the stored (old) value.

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- rst_n  input  1  asynchronous active-low reset; clears all registers.
- RegWrite  input  1  write enable, sampled on the rising clk edge.
- rs1  input  5  read address, port 1.
- rs2  input  5  read address, port 2.
- rd  input  5  write address.
- Result  input  XLEN  write data.
- RD1  output  XLEN  contents of register rs1.
- WriteData  output  XLEN  contents of register rs2.

Behaviour:
- Storage: registers x0..x31, XLEN bits each.
- Reset:
  - rst_n low clears x1..x31 to 0 immediately, without waiting for a clock edge.
  - While rst_n is low, writes are blocked and RD1 = WriteData = 0 for any address.
  - Deassertion takes effect at the next rising edge. A write presented on that edge is performed.
- Write:
  - On posedge clk with rst_n high, RegWrite=1 and rd!=0: reg[rd] <= Result.
  - RegWrite=0: no change.
  - rd=0: the write is silently discarded.
- Read:
  - Purely combinational. RD1 = reg[rs1] and WriteData = reg[rs2], with zero clock latency.
  - Outputs update in the same delta as address or storage changes.
  - Address 0 always returns 0 on both ports.
- Write then read latency: a value written at edge N is visible on the read ports immediately after edge N.
- Same-cycle read of the write target before the edge:
  - BYPASS=0: the old value is returned.
  - BYPASS=1: Result is returned when RegWrite=1, rd!=0 and rs==rd.
  - With either setting, x0 is never bypassed.
- Both read ports may address the same register simultaneously; both return identical data.
- Reset mid-write: if rst_n falls in the same cycle as a pending write, reset wins. The register stays 0.
- No X propagation after reset: every readable location has a defined value.
- Address inputs are 5 bits wide, so every value is legal. There is no out-of-range handling.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 for 2 cycles, then sweep rs1 and rs2 over 0..31.
  - Required: RD1 = WriteData = 0x00000000 for every address.
- Write all, read all:
  - Stimulus: with RegWrite=1, on consecutive edges write rd=i with pseudo-random data, e.g. rd=1 gets 0x12153524 and rd=2 gets 0xC0895E81. Then set RegWrite=0 and set rs1=rs2=i for i = 0..31.
  - Required: both ports return the value written to register i for i>=1. Register 0 returns 0 even though a write to rd=0 was attempted.
- x0 immunity:
  - Stimulus: RegWrite=1, rd=0, Result=0xFFFFFFFF for one edge. Then rs1=0 and rs2=0.
  - Required: RD1 = WriteData = 0.
- Write-enable gating:
  - Stimulus: write 0xA5A5A5A5 to x5. Then apply RegWrite=0, rd=5, Result=0x5A5A5A5A for one edge.
  - Required: x5 reads 0xA5A5A5A5.
- Same-cycle read/write:
  - Stimulus: x7 holds 0x11111111. Set rs1=rs2=7 and write 0x22222222 to rd=7.
  - Required before the edge: 0x11111111 with BYPASS=0, and 0x22222222 with BYPASS=1.
  - Required after the edge: 0x22222222 on both ports in both configurations.
- Async reset mid-operation:
  - Stimulus: x3 holds 0xDEADBEEF. Drop rst_n between clock edges.
  - Required: RD1 with rs1=3 goes to 0 before the next edge. x3 stays 0 after rst_n is released, until it is rewritten.

Source files
------------

// File: rtl/rv32i_regfile.sv
// RV32I integer register file: 32 x XLEN storage, two combinational read
// ports (rs1 -> RD1, rs2 -> WriteData) and one synchronous write port.
// x0 reads as zero and ignores writes. BYPASS selects write-through reads.
module rv32i_regfile #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     RegWrite,
    input  logic [$clog2(NREGS)-1:0] rs1,
    input  logic [$clog2(NREGS)-1:0] rs2,
    input  logic [$clog2(NREGS)-1:0] rd,
    input  logic [XLEN-1:0]          Result,
    output logic [XLEN-1:0]          RD1,
    output logic [XLEN-1:0]          WriteData
);

    localparam int AW = $clog2(NREGS);

    // Entry 0 exists only so every address indexes in range; it is never
    // written and the read path forces it to zero regardless.
    logic [XLEN-1:0] regs [NREGS];

    logic write_en;
    assign write_en = RegWrite && (rd != '0);

    // Storage: asynchronous clear, write on rising edge when enabled and rd != 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[rd] <= Result;
        end
    end

    // Read port 1: x0 is zero, optional write-through, otherwise stored value
    always_comb begin
        RD1 = '0;
        if (rst_n && (rs1 != '0)) begin
            if ((BYPASS != 0) && write_en && (rs1 == rd)) begin
                RD1 = Result;
            end else begin
                RD1 = regs[rs1];
            end
        end
    end

    // Read port 2: same rules as port 1, addressed by rs2
    always_comb begin
        WriteData = '0;
        if (rst_n && (rs2 != '0)) begin
            if ((BYPASS != 0) && write_en && (rs2 == rd)) begin
                WriteData = Result;
            end else begin
                WriteData = regs[rs2];
            end
        end
    end

    logic [AW-1:0] unused_aw;
    assign unused_aw = '0;

endmodule

// File: tb/tb_rv32i_regfile.sv
// Testbench for rv32i_regfile: one instance per BYPASS setting, driven with
// shared stimulus and checked against an array model every falling edge,
// plus directed literal checks from the test plan.
`timescale 1ns/1ps
module tb_rv32i_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] Result;
    logic [31:0] rd1_0, wd_0, rd1_1, wd_1;

    int total = 0;
    int bad   = 0;
    bit run   = 1'b0;

    logic [31:0] mdl [32] = '{default: 32'h0};

    rv32i_regfile #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite),
        .rs1(rs1), .rs2(rs2), .rd(rd), .Result(Result),
        .RD1(rd1_0), .WriteData(wd_0)
    );

    rv32i_regfile #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite),
        .rs1(rs1), .rs2(rs2), .rd(rd), .Result(Result),
        .RD1(rd1_1), .WriteData(wd_1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Architectural state: cleared by reset, written on an enabled edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        end else if (RegWrite && rd != 5'd0) begin
            mdl[rd] = Result;
        end
    end

    function automatic logic [31:0] exp_read(input logic [4:0] rs, input bit byp);
        if (!rst_n || rs == 5'd0) return 32'h0;
        if (byp && RegWrite && rd != 5'd0 && rd == rs) return Result;
        return mdl[rs];
    endfunction

    always @(negedge clk) begin
        if (run) begin
            check("b0_rd1", rd1_0, exp_read(rs1, 1'b0));
            check("b0_wd",  wd_0,  exp_read(rs2, 1'b0));
            check("b1_rd1", rd1_1, exp_read(rs1, 1'b1));
            check("b1_wd",  wd_1,  exp_read(rs2, 1'b1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic [31:0] e0, input logic [31:0] e1);
        check({name, "_b0_rd1"}, rd1_0, e0);
        check({name, "_b0_wd"},  wd_0,  e0);
        check({name, "_b1_rd1"}, rd1_1, e1);
        check({name, "_b1_wd"},  wd_1,  e1);
    endtask

    initial begin
        rst_n = 1'b0; RegWrite = 1'b0; rs1 = '0; rs2 = '0; rd = '0; Result = '0;
        repeat (2) @(posedge clk);
        #1;
        run = 1'b1;

        // Reset sweep with a write attempt that must be blocked
        RegWrite = 1'b1; rd = 5'd4; Result = 32'hFFFF0000;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i);
            #1;
            check_all("reset_sweep", 32'h0, 32'h0);
        end

        step(); rst_n = 1'b1; RegWrite = 1'b0;

        // Write all registers, including an attempt on x0
        for (int i = 0; i < 32; i++) begin
            step();
            RegWrite = 1'b1; rd = 5'(i);
            Result = (i == 1) ? 32'h12153524 : (i == 2) ? 32'hC0895E81 : $urandom;
        end
        step(); RegWrite = 1'b0; rs1 = 5'd1; rs2 = 5'd2;
        #2;
        check("x1_rd1", rd1_0, 32'h12153524);
        check("x2_wd",  wd_0,  32'hC0895E81);
        check("mdl_x1", mdl[1], 32'h12153524);
        check("mdl_x2", mdl[2], 32'hC0895E81);
        for (int i = 0; i < 32; i++) begin
            step(); rs1 = 5'(i); rs2 = 5'(i);
        end
        step(); rs1 = 5'd0; rs2 = 5'd0;
        #2;
        check_all("x0_after_all", 32'h0, 32'h0);

        // x0 immunity
        step(); RegWrite = 1'b1; rd = 5'd0; Result = 32'hFFFFFFFF;
        step(); RegWrite = 1'b0;
        #2;
        check_all("x0_immune", 32'h0, 32'h0);
        check("mdl_x0", mdl[0], 32'h0);

        // Write-enable gating
        step(); RegWrite = 1'b1; rd = 5'd5; Result = 32'hA5A5A5A5;
        step(); RegWrite = 1'b0; Result = 32'h5A5A5A5A;
        step(); rs1 = 5'd5; rs2 = 5'd5;
        #2;
        check_all("we_gate", 32'hA5A5A5A5, 32'hA5A5A5A5);

        // Same-cycle read/write
        step(); RegWrite = 1'b1; rd = 5'd7; Result = 32'h11111111;
        step(); Result = 32'h22222222; rs1 = 5'd7; rs2 = 5'd7;
        #2;
        check_all("rw_before", 32'h11111111, 32'h22222222);
        step(); RegWrite = 1'b0;
        #2;
        check_all("rw_after", 32'h22222222, 32'h22222222);

        // Async reset mid-operation, racing a pending write
        step(); RegWrite = 1'b1; rd = 5'd3; Result = 32'hDEADBEEF;
        step(); RegWrite = 1'b0; rs1 = 5'd3; rs2 = 5'd3;
        #1;
        check_all("x3_set", 32'hDEADBEEF, 32'hDEADBEEF);
        RegWrite = 1'b1; Result = 32'hCAFEF00D;
        #1 rst_n = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 32'h0);
        step(); rst_n = 1'b1; RegWrite = 1'b0;
        step();
        #2;
        check_all("x3_stays0", 32'h0, 32'h0);
        check("mdl_x3", mdl[3], 32'h0);

        // Write presented on the first edge after deassertion is performed
        step(); rst_n = 1'b0;
        step(); rst_n = 1'b1; RegWrite = 1'b1; rd = 5'd9; Result = 32'h0BADF00D;
        step(); RegWrite = 1'b0; rs1 = 5'd9; rs2 = 5'd9;
        #2;
        check_all("first_edge_wr", 32'h0BADF00D, 32'h0BADF00D);

        // Random traffic with occasional mid-cycle reset pulses
        for (int n = 0; n < 500; n++) begin
            step();
            if (!rst_n) rst_n = 1'b1;
            RegWrite = ($urandom_range(0, 3) != 0);
            rd  = 5'($urandom_range(0, 31));
            rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            Result = $urandom;
            if ($urandom_range(0, 60) == 0) begin
                #2 rst_n = 1'b0;
            end
        end

        step();
        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
